i2s_rx_deserializer: RTL and testbench
======================================

# i2s_rx_deserializer

Receives the serial line-in data stream from the ADC. It uses the bit clock and word clock generated by `i2s_clock_divider` to recover parallel left and right PCM samples. It sits directly downstream of `i2s_clock_divider` and feeds the pedal effects chain with one left/right sample pair per audio frame. The block runs entirely in the `line_in_mclk` domain and treats `line_in_sclk` and `line_in_lrclk` as sampled signals, not as clocks.

## Interface

**Parameters**
- `DATA_WIDTH`, default 24: sample width captured per channel, MSB first.
- `SLOT_BITS`, default 32: `line_in_sclk` periods per channel slot. Bits after `DATA_WIDTH` in a slot are ignored.

**Ports**

Clock is one clock, `line_in_mclk`. Reset is `rst`, synchronous and active-high.

- `line_in_mclk`  in  1: system/master clock.
- `rst`  in  1: synchronous, active-high reset.
- `line_in_sclk`  in  1: I2S bit clock from `i2s_clock_divider`. Period is at least 4 `line_in_mclk` cycles.
- `line_in_lrclk`  in  1: I2S word clock. 0 = left slot, 1 = right slot.
- `line_in_sdata`  in  1: ADC serial data. Changes on `line_in_sclk` falling edges.
- `left_sample`  out  DATA_WIDTH: last complete left word, two's complement.
- `right_sample`  out  DATA_WIDTH: last complete right word.
- `sample_valid`  out  1: one-cycle pulse when `left_sample`/`right_sample` update together.
- `sync_err`  out  1: sticky flag for a slot shorter than `DATA_WIDTH` bits. Cleared only by `rst`.

## Operation

**Input stage**
- Register `line_in_sclk`, `line_in_lrclk` and `line_in_sdata` once into s1.
- Register `sclk` s1 again into s2.
- Bit event `rise` = `sclk_s1 & ~sclk_s2`. All state below advances only on cycles where `rise` is high.

**Per `rise`**
- Sample `lr = lrclk_s1` and `d = sdata_s1`. Compare `lr` with the previously stored `lr_prev`.
- `lr != lr_prev` (slot boundary):
  - `d` is the last bit of the previous slot (I2S one-bit delay) and is discarded.
  - Set `bit_cnt` = 0 and `cur_ch` = `lr`.
  - If `state` = CAPTURE and the old slot's `bit_cnt < DATA_WIDTH`: set `sync_err` = 1, go to HUNT.
- Otherwise:
  - Increment `bit_cnt`, saturating at `SLOT_BITS`.
  - While `bit_cnt` (before increment) < `DATA_WIDTH`: shift `d` into `shreg` LSB-side.
- When the shift count reaches `DATA_WIDTH`: latch `shreg` into `left_hold` (`cur_ch` = 0) or `right_hold` (`cur_ch` = 1), then set the matching `have_l` / `have_r`.

**State machine**
- WAIT_LR (reset state): ignore data until the first `lr` transition. On a transition to 0 (left slot start) go to CAPTURE. A transition to 1 stays in WAIT_LR.
- CAPTURE: normal operation.
  - When the right word completes and `have_l` = 1: copy `left_hold` and `right_hold` to the outputs, pulse `sample_valid`, clear `have_l`/`have_r`.
  - A right word completing with `have_l` = 0 is dropped.
- HUNT: entered on a short slot. Clear `have_l`/`have_r`. Behaves as WAIT_LR, so recovery starts at the next left slot start.

**Reset and edge cases**
- Reset (any time, including mid-slot):
  - `left_sample`, `right_sample`, `sample_valid`, `sync_err` = 0.
  - `shreg`, holds, `bit_cnt` = 0; `lr_prev` = 0.
  - `state` = WAIT_LR.
  - Partial words are discarded.
- `SLOT_BITS` overrun (no `lr` change after `SLOT_BITS` bits): the counter saturates and no error is flagged.

## Timing

- Edge 1 is the first `line_in_mclk` edge that samples `line_in_sclk` high.
- `shreg` / `bit_cnt` update at edge 2.
- Holds and outputs update, and `sample_valid` goes high, at edge 3.
- `sample_valid` is high for exactly one cycle, once per frame (every 2×`SLOT_BITS` `sclk` periods).
- Outputs hold their value between pulses.
- With mclk = 512·fs and sclk = 64·fs, pulses are spaced exactly 512 `line_in_mclk` cycles in steady state.
- Latency from the right-word LSB `rise` to valid: 2 `line_in_mclk` cycles after edge 1.

## Test plan

Stimulus uses mclk period 44.28 ns, sclk = mclk/8, lrclk = sclk/64, with defaults (24-bit data in 32-bit slots).

1. **Basic capture:** reset, then frames with left 0xABCDEF and right 0x123456 → after the first full frame, `left_sample` = 0xABCDEF, `right_sample` = 0x123456, with one `sample_valid` pulse per frame.
2. **Bit alignment:** left 0x800000, right 0x000001, with padding bits set to 1 → outputs are exactly 0x800000 / 0x000001. This checks the one-bit delay and that bits past `DATA_WIDTH` are ignored.
3. **No word clock:** `line_in_lrclk` held at 0 for 3 frame times after reset → `sample_valid` never asserts and all outputs stay 0.
4. **Short slot:** one left slot only 16 `sclk` periods long → `sync_err` goes high and stays high, no pulse for that frame. The next full frame yields correct data and a pulse.
5. **Reset mid-frame:** `rst` asserted for 1 cycle in the middle of a right slot → outputs are 0 on the next cycle. The first pulse after reset comes only after a full left slot and a full right slot.
6. **Streaming:** 4 consecutive frames with distinct values → exactly 4 pulses, 512 cycles apart, each with matching left/right data.

Source files
------------

// File: rtl/i2s_rx_deserializer.sv
// I2S receiver: oversamples sclk/lrclk/sdata in the mclk domain and recovers
// left/right PCM words, presenting one pair per frame with a valid pulse.
module i2s_rx_deserializer #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned SLOT_BITS  = 32
) (
    input  logic                  line_in_mclk,
    input  logic                  rst,
    input  logic                  line_in_sclk,
    input  logic                  line_in_lrclk,
    input  logic                  line_in_sdata,
    output logic [DATA_WIDTH-1:0] left_sample,
    output logic [DATA_WIDTH-1:0] right_sample,
    output logic                  sample_valid,
    output logic                  sync_err
);

    localparam int unsigned CNT_W = $clog2(SLOT_BITS + 1);

    localparam logic [CNT_W-1:0] DW_CNT   = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] SLOT_CNT = CNT_W'(SLOT_BITS);

    typedef enum logic [1:0] {
        StWaitLr,
        StCapture,
        StHunt
    } state_t;

    logic                  r_sclk_s1;
    logic                  r_sclk_s2;
    logic                  r_lrclk_s1;
    logic                  r_sdata_s1;

    state_t                r_state;
    logic                  r_lr_prev;
    logic                  r_cur_ch;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic                  r_word_done;
    logic                  r_done_ch;
    logic [DATA_WIDTH-1:0] r_left_hold;
    logic                  r_have_l;

    logic [DATA_WIDTH-1:0] r_left_sample;
    logic [DATA_WIDTH-1:0] r_right_sample;
    logic                  r_sample_valid;
    logic                  r_sync_err;

    logic                  w_rise;
    logic                  w_boundary;

    // sclk/lrclk/sdata are data here, not clocks: sample them into mclk.
    always_ff @(posedge line_in_mclk) begin
        if (rst) begin
            r_sclk_s1  <= 1'b0;
            r_sclk_s2  <= 1'b0;
            r_lrclk_s1 <= 1'b0;
            r_sdata_s1 <= 1'b0;
        end else begin
            r_sclk_s1  <= line_in_sclk;
            r_sclk_s2  <= r_sclk_s1;
            r_lrclk_s1 <= line_in_lrclk;
            r_sdata_s1 <= line_in_sdata;
        end
    end

    assign w_rise     = r_sclk_s1 & ~r_sclk_s2;
    assign w_boundary = w_rise & (r_lrclk_s1 != r_lr_prev);

    always_ff @(posedge line_in_mclk) begin
        if (rst) begin
            r_state        <= StWaitLr;
            r_lr_prev      <= 1'b0;
            r_cur_ch       <= 1'b0;
            r_bit_cnt      <= '0;
            r_shreg        <= '0;
            r_word_done    <= 1'b0;
            r_done_ch      <= 1'b0;
            r_left_hold    <= '0;
            r_have_l       <= 1'b0;
            r_left_sample  <= '0;
            r_right_sample <= '0;
            r_sample_valid <= 1'b0;
            r_sync_err     <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            r_word_done    <= 1'b0;

            if (w_rise) begin
                r_lr_prev <= r_lrclk_s1;
                if (w_boundary) begin
                    // The bit sampled here is the previous slot's last bit (I2S delay).
                    r_bit_cnt <= '0;
                    r_cur_ch  <= r_lrclk_s1;
                    unique case (r_state)
                        StCapture: begin
                            if (r_bit_cnt < DW_CNT) begin
                                r_sync_err <= 1'b1;
                                r_state    <= StHunt;
                                r_have_l   <= 1'b0;
                            end
                        end
                        default: begin
                            if (!r_lrclk_s1) begin
                                r_state <= StCapture;
                            end
                        end
                    endcase
                end else begin
                    if (r_bit_cnt != SLOT_CNT) begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                    if (r_bit_cnt < DW_CNT) begin
                        r_shreg <= {r_shreg[DATA_WIDTH-2:0], r_sdata_s1};
                        if ((r_bit_cnt == LAST_CNT) && (r_state == StCapture)) begin
                            r_word_done <= 1'b1;
                            r_done_ch   <= r_cur_ch;
                        end
                    end
                end
            end

            // Word completed on the previous cycle; shreg is stable until the next rise.
            if (r_word_done) begin
                if (!r_done_ch) begin
                    r_left_hold <= r_shreg;
                    r_have_l    <= 1'b1;
                end else if (r_have_l) begin
                    r_left_sample  <= r_left_hold;
                    r_right_sample <= r_shreg;
                    r_sample_valid <= 1'b1;
                    r_have_l       <= 1'b0;
                end
            end
        end
    end

    assign left_sample  = r_left_sample;
    assign right_sample = r_right_sample;
    assign sample_valid = r_sample_valid;
    assign sync_err     = r_sync_err;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Randomised bench for i2s_rx_deserializer: slot lists are serialised as I2S and
// compared against a slot-level reference model of the expected sample pairs.
`timescale 1ns/10ps
module tb_i2s_rx_deserializer;

    localparam int DW = 24;

    logic          mclk  = 1'b0;
    logic          rst   = 1'b1;
    logic          sclk  = 1'b0;
    logic          lrclk = 1'b0;
    logic          sdata = 1'b0;
    logic [DW-1:0] left_s;
    logic [DW-1:0] right_s;
    logic          valid;
    logic          err;

    typedef struct {
        logic        lr;
        int          len;
        logic [31:0] bits;
    } slot_t;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        int            cyc;
    } pair_t;

    slot_t seg[$];
    pair_t exp_q[$];
    pair_t obs_q[$];
    logic  exp_err;
    logic  carry;
    int    cyc = 0;
    int    n_tests = 0;
    int    n_fail = 0;

    always #22.14 mclk = ~mclk;

    i2s_rx_deserializer #(
        .DATA_WIDTH(DW),
        .SLOT_BITS (32)
    ) u_dut (
        .line_in_mclk (mclk),
        .rst          (rst),
        .line_in_sclk (sclk),
        .line_in_lrclk(lrclk),
        .line_in_sdata(sdata),
        .left_sample  (left_s),
        .right_sample (right_s),
        .sample_valid (valid),
        .sync_err     (err)
    );

    always @(posedge mclk) cyc <= cyc + 1;

    always @(negedge mclk) begin : mon
        pair_t p;
        if (valid) begin
            p.l   = left_s;
            p.r   = right_s;
            p.cyc = cyc;
            obs_q.push_back(p);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic add_slot(input logic lr, input int len, input logic [31:0] bits);
        slot_t s;
        s.lr   = lr;
        s.len  = len;
        s.bits = bits;
        seg.push_back(s);
    endtask

    task automatic add_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                             input logic [7:0] pad);
        add_slot(1'b0, 32, {l, pad});
        add_slot(1'b1, 32, {r, pad});
    endtask

    // One sclk period: 4 mclk low (data/lr change at the falling edge), 4 mclk high.
    task automatic drive_period(input logic lr, input logic d);
        @(negedge mclk);
        sclk  = 1'b0;
        lrclk = lr;
        sdata = d;
        repeat (4) @(negedge mclk);
        sclk = 1'b1;
        repeat (3) @(negedge mclk);
    endtask

    task automatic play();
        logic d;
        foreach (seg[k]) begin
            for (int i = 0; i < seg[k].len; i++) begin
                d = (i == 0) ? carry : seg[k].bits[32-i];
                drive_period(seg[k].lr, d);
            end
            carry = seg[k].bits[32-seg[k].len];
        end
    endtask

    // Slot-level view: a slot of L periods carries L-1 data bits after the one-bit
    // delay; capture starts at a left slot that begins with an lr change.
    task automatic model();
        logic          prev_lr    = 1'b0;
        logic          locked     = 1'b0;
        logic          have_l     = 1'b0;
        logic          prev_short = 1'b0;
        logic [DW-1:0] lv         = '0;
        pair_t         p;
        exp_q.delete();
        exp_err = 1'b0;
        foreach (seg[k]) begin
            if (seg[k].lr != prev_lr) begin
                if (locked && prev_short) begin
                    exp_err = 1'b1;
                    locked  = 1'b0;
                    have_l  = 1'b0;
                end else if (!locked && (seg[k].lr == 1'b0)) begin
                    locked = 1'b1;
                end
            end
            prev_lr    = seg[k].lr;
            prev_short = (seg[k].len - 1) < DW;
            if (locked && !prev_short) begin
                if (seg[k].lr == 1'b0) begin
                    lv     = seg[k].bits[31:32-DW];
                    have_l = 1'b1;
                end else if (have_l) begin
                    p.l   = lv;
                    p.r   = seg[k].bits[31:32-DW];
                    p.cyc = 0;
                    exp_q.push_back(p);
                    have_l = 1'b0;
                end
            end
        end
    endtask

    task automatic run_segment(input string name, input bit check_gap);
        int n;
        model();
        obs_q.delete();
        play();
        repeat (8) @(negedge mclk);
        check_eq({name, ".pulses"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s.left[%0d]", name, i), obs_q[i].l, exp_q[i].l);
            check_eq($sformatf("%s.right[%0d]", name, i), obs_q[i].r, exp_q[i].r);
        end
        if (check_gap) begin
            for (int i = 1; i < obs_q.size(); i++) begin
                check_eq($sformatf("%s.gap[%0d]", name, i), obs_q[i].cyc - obs_q[i-1].cyc, 512);
            end
        end
        check_eq({name, ".sync_err"}, err, exp_err);
        if (exp_q.size() > 0) begin
            check_eq({name, ".hold_left"}, left_s, exp_q[exp_q.size()-1].l);
            check_eq({name, ".hold_right"}, right_s, exp_q[exp_q.size()-1].r);
        end else begin
            check_eq({name, ".idle_left"}, left_s, 0);
            check_eq({name, ".idle_right"}, right_s, 0);
        end
        seg.delete();
    endtask

    task automatic do_reset();
        @(negedge mclk);
        rst   = 1'b1;
        sclk  = 1'b0;
        lrclk = 1'b0;
        sdata = 1'b0;
        repeat (3) @(negedge mclk);
        rst = 1'b0;
    endtask

    initial begin
        carry = 1'b0;
        do_reset();
        check_eq("reset.left", left_s, 0);
        check_eq("reset.right", right_s, 0);
        check_eq("reset.valid", valid, 0);
        check_eq("reset.sync_err", err, 0);

        add_slot(1'b1, 32, $urandom);
        repeat (3) add_frame(24'hABCDEF, 24'h123456, 8'h00);
        run_segment("basic", 1'b1);

        do_reset();
        add_slot(1'b1, 32, 32'hFFFF_FFFF);
        add_frame(24'h800000, 24'h000001, 8'hFF);
        run_segment("align", 1'b0);

        do_reset();
        repeat (6) add_slot(1'b0, 32, $urandom);
        run_segment("no_lrclk", 1'b0);

        do_reset();
        add_slot(1'b1, 32, $urandom);
        add_slot(1'b0, 32, $urandom);
        add_slot(1'b1, 32, $urandom);
        add_slot(1'b0, 16, $urandom);
        add_slot(1'b1, 32, $urandom);
        repeat (4) add_slot(1'b0 ^ (seg.size() % 2 == 0), 32, $urandom);
        run_segment("short_slot", 1'b0);

        do_reset();
        add_slot(1'b1, 32, $urandom);
        add_slot(1'b0, 32, $urandom);
        add_slot(1'b1, 32, $urandom);
        add_slot(1'b0, 32, $urandom);
        add_slot(1'b1, 16, $urandom);
        run_segment("pre_rst", 1'b0);
        @(negedge mclk);
        sclk = 1'b0;
        repeat (2) @(negedge mclk);
        rst = 1'b1;
        @(negedge mclk);
        rst = 1'b0;
        check_eq("mid_rst.left", left_s, 0);
        check_eq("mid_rst.right", right_s, 0);
        check_eq("mid_rst.valid", valid, 0);
        add_slot(1'b1, 16, $urandom);
        repeat (4) add_slot((seg.size() % 2 == 0), 32, $urandom);
        run_segment("post_rst", 1'b0);

        do_reset();
        add_slot(1'b1, 32, $urandom);
        repeat (8) add_slot((seg.size() % 2 == 0), 32, $urandom);
        run_segment("stream", 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
